// File: rtl/hex_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// hex_scan_driver_pkg : shared constants and leading-zero blank mask helper
// Revision: 1.0
// ============================================================================
package hex_scan_driver_pkg;

   localparam int unsigned c_NIBBLE_W            = 4;
   localparam int unsigned c_MAX_DIGITS          = 8;
   localparam int unsigned c_MAX_IDX_W           = 3;
   localparam int unsigned c_MAX_VAL_W           = c_MAX_DIGITS * c_NIBBLE_W;
   localparam int unsigned c_DEFAULT_REFRESH_DIV = 50000;
   localparam int unsigned c_DEFAULT_DEAD_CYCLES = 2;

   // Bit i set when every nibble from the top digit down to i is zero; digit 0 never set.
   function automatic logic [c_MAX_DIGITS-1:0] lz_blank_mask(
      input logic [c_MAX_VAL_W-1:0] value,
      input int unsigned            num_digits
   );
      logic [c_MAX_DIGITS-1:0] mask;
      logic                    zero_run;
      mask     = '0;
      zero_run = 1'b1;
      for (int i = c_MAX_DIGITS - 1; i >= 1; i--) begin
         if (int'(num_digits) > i) begin
            zero_run = zero_run && (value[i*c_NIBBLE_W +: c_NIBBLE_W] == '0);
            mask[i]  = zero_run;
         end
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_driver_prescaler.sv
`default_nettype none
// ============================================================================
// scan_prescaler : slot divider producing a terminal-count tick and dead flag
// Revision: 1.0
// ============================================================================
module scan_prescaler #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick,
   output logic o_dead
);

   localparam int unsigned           c_CNT_W = $clog2(REFRESH_DIV);
   localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(REFRESH_DIV - 1);
   localparam logic [c_CNT_W-1:0]    c_DEAD  = c_CNT_W'(DEAD_CYCLES);

   logic [c_CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (r_count == c_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_CNT_W'(1);
      end
   end

   assign o_tick = (r_count == c_LAST);
   assign o_dead = (r_count < c_DEAD);

endmodule
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// hex_scan_driver : time-multiplexed hex scan with double buffer and LZ blank
// Revision: 1.0
// ============================================================================
module hex_scan_driver
   import hex_scan_driver_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = c_DEFAULT_REFRESH_DIV,
   parameter int unsigned DEAD_CYCLES = c_DEFAULT_DEAD_CYCLES
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_DIGITS*c_NIBBLE_W-1:0] value_in,
   input  logic                             load,
   input  logic                             blank_lz,
   output logic [c_NIBBLE_W-1:0]            digit_nibble,
   output logic [NUM_DIGITS-1:0]            digit_sel,
   output logic                             load_ack,
   output logic                             frame_done
);

   localparam int unsigned           c_VAL_W    = NUM_DIGITS * c_NIBBLE_W;
   localparam int unsigned           c_IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);

   logic                      w_tick;
   logic                      w_dead;
   logic                      w_wrap;
   logic                      w_blank;
   logic [c_MAX_DIGITS-1:0]   w_mask;
   logic [c_MAX_IDX_W-1:0]    w_idx_ext;
   logic [c_NIBBLE_W-1:0]     w_nibble;
   logic [NUM_DIGITS-1:0]     w_sel_n;

   logic [c_IDX_W-1:0]        r_index;
   logic [c_VAL_W-1:0]        r_display;
   logic [c_VAL_W-1:0]        r_pending;
   logic                      r_pending_valid;

   scan_prescaler #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick),
      .o_dead (w_dead)
   );

   assign w_wrap = w_tick && (r_index == c_LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_index <= '0;
      end else if (w_tick) begin
         r_index <= (r_index == c_LAST_IDX) ? '0 : r_index + c_IDX_W'(1);
      end
   end

   // A load landing on the wrapping tick bypasses the pending buffer entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_display       <= '0;
         r_pending       <= '0;
         r_pending_valid <= 1'b0;
      end else if (w_wrap) begin
         if (load) begin
            r_display <= value_in;
         end else if (r_pending_valid) begin
            r_display <= r_pending;
         end
         r_pending_valid <= 1'b0;
      end else if (load) begin
         r_pending       <= value_in;
         r_pending_valid <= 1'b1;
      end
   end

   assign w_mask    = lz_blank_mask(c_MAX_VAL_W'(r_display), NUM_DIGITS);
   assign w_idx_ext = c_MAX_IDX_W'(r_index);
   assign w_blank   = blank_lz && w_mask[w_idx_ext];
   assign w_nibble  = r_display[{r_index, 2'b00} +: c_NIBBLE_W];

   always_comb begin
      w_sel_n = '1;
      if (!w_dead && !w_blank) begin
         w_sel_n[r_index] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_nibble <= '0;
         digit_sel    <= '1;
         load_ack     <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         digit_nibble <= w_nibble;
         digit_sel    <= w_sel_n;
         load_ack     <= w_wrap && (load || r_pending_valid);
         frame_done   <= w_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_hex_scan_driver : randomized scoreboard bench against a time-based model
// Revision: 1.0
// ============================================================================
module tb_hex_scan_driver;

   localparam int N    = 4;
   localparam int DIV  = 4;
   localparam int DEAD = 1;

   typedef struct packed {
      logic [3:0] nib;
      logic [3:0] sel;
      logic       ack;
      logic       fd;
   } obs_t;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic [15:0] value_in = '0;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  digit_nibble;
   logic [3:0]  digit_sel;
   logic        load_ack;
   logic        frame_done;

   obs_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          started  = 1'b0;

   // Model state: cycles since reset release, shown value, buffered value.
   int unsigned t      = 0;
   logic [15:0] m_disp = '0;
   logic [15:0] m_pend = '0;
   bit          m_pv   = 1'b0;

   always #5 clk = ~clk;

   hex_scan_driver #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (DIV),
      .DEAD_CYCLES (DEAD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .value_in     (value_in),
      .load         (load),
      .blank_lz     (blank_lz),
      .digit_nibble (digit_nibble),
      .digit_sel    (digit_sel),
      .load_ack     (load_ack),
      .frame_done   (frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   function automatic bit next_is_wrap();
      return ((t % DIV) == DIV - 1) && (((t / DIV) % N) == N - 1);
   endfunction

   // Drive one cycle at the falling edge and enqueue what the next rising edge must show.
   task automatic cycle(input bit r, input bit ld, input logic [15:0] v, input bit bl,
                        input bit async_chk);
      obs_t        e;
      int          p;
      int          idx;
      bit          wrap;
      logic [15:0] upper;
      @(negedge clk);
      rst      = r;
      load     = ld;
      value_in = v;
      blank_lz = bl;
      started  = 1'b1;
      if (r) begin
         if (async_chk) begin
            #1;
            check("async_rst_sel", 32'(digit_sel), 32'hF);
            check("async_rst_nibble", 32'(digit_nibble), 32'h0);
            check("async_rst_ack", 32'(load_ack), 32'h0);
            check("async_rst_fd", 32'(frame_done), 32'h0);
         end
         e.nib = 4'h0; e.sel = 4'hF; e.ack = 1'b0; e.fd = 1'b0;
         t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      end else begin
         p     = int'(t % DIV);
         idx   = int'((t / DIV) % N);
         wrap  = next_is_wrap();
         upper = m_disp >> (4 * idx);
         e.nib = upper[3:0];
         if (p < DEAD || (bl && idx > 0 && upper == 16'h0)) e.sel = 4'hF;
         else e.sel = ~(4'(1) << idx);
         e.fd  = wrap;
         e.ack = wrap && (ld || m_pv);
         if (wrap) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
         end else if (ld) begin
            m_pend = v;
            m_pv   = 1'b1;
         end
         t++;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit bl);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, bl, 1'b0);
   endtask

   task automatic go_to_wrap(input bit bl);
      for (int k = 0; k < N * DIV && !next_is_wrap(); k++) cycle(1'b0, 1'b0, 16'h0, bl, 1'b0);
   endtask

   // Monitor: one expected entry per rising edge once stimulus has started.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
            end else begin
               e = exp_q.pop_front();
               check("digit_nibble", 32'(digit_nibble), 32'(e.nib));
               check("digit_sel", 32'(digit_sel), 32'(e.sel));
               check("load_ack", 32'(load_ack), 32'(e.ack));
               check("frame_done", 32'(frame_done), 32'(e.fd));
            end
         end
      end
   end

   initial begin
      logic [15:0] v;
      bit          bl;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2 * N * DIV, 1'b0);

      idle(3, 1'b0);
      cycle(1'b0, 1'b1, 16'h1A2F, 1'b0, 1'b0);
      idle(2 * N * DIV, 1'b0);

      go_to_wrap(1'b0);
      idle(2, 1'b0);
      cycle(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
      idle(3, 1'b0);
      cycle(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0);
      idle(2 * N * DIV, 1'b0);

      go_to_wrap(1'b1);
      idle(1, 1'b1);
      cycle(1'b0, 1'b1, 16'h0050, 1'b1, 1'b0);
      idle(2 * N * DIV, 1'b1);
      cycle(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      idle(2 * N * DIV, 1'b1);

      go_to_wrap(1'b0);
      cycle(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      idle(N * DIV + 2, 1'b0);

      go_to_wrap(1'b0);
      idle(1, 1'b0);
      cycle(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
      for (int k = 0; k < N * DIV && !(((t / DIV) % N) == 2 && (t % DIV) == 1); k++)
         idle(1, 1'b0);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2 * N * DIV, 1'b0);

      bl = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) bl = ~bl;
         v = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if (next_is_wrap() && $urandom_range(0, 1) == 0)
            cycle(1'b0, 1'b1, v, bl, 1'b0);
         else
            cycle(1'b0, ($urandom_range(0, 5) == 0), v, bl, 1'b0);
      end

      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Upstream stage of the per-digit 7-segment decoder: time-multiplexes a packed hex value across NUM_DIGITS common-anode digits.
- Presents one 4-bit nibble per scan slot to a single shared decoder, plus an active-low digit select.
- Double-buffers the displayed value so an update never tears mid-frame.
- Optionally blanks leading zeros.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 2..8.
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range >= 4.
- DEAD_CYCLES, 2, cycles at slot start with all digits off (anti-ghosting); legal range 0..REFRESH_DIV-2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- value_in  in  4*NUM_DIGITS  packed hex value; digit 0 = bits [3:0] (LSD).
- load  in  1  one-cycle strobe; captures value_in.
- blank_lz  in  1  enable leading-zero blanking; sampled each cycle.
- digit_nibble  out  4  nibble to the 7-seg decoder.
- digit_sel  out  NUM_DIGITS  active-low anode enables; at most one bit low.
- load_ack  out  1  one-cycle pulse when a loaded value becomes displayed.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.

Behaviour:
- Reset (async assert) sets every register to its reset value:
  - prescaler 0, slot index 0, display_reg 0, pending_reg 0, pending_valid 0.
  - digit_sel all 1s, digit_nibble 0, load_ack 0, frame_done 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler == REFRESH_DIV-1).
- Slot index:
  - On tick, the index advances 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
  - frame_done is asserted in the cycle after the tick that wraps the index NUM_DIGITS-1 -> 0.
- Load path:
  - load captures value_in into pending_reg and sets pending_valid.
  - Repeated loads within a frame: the last one wins.
- Commit:
  - Occurs on the wrapping tick when pending_valid = 1: display_reg <= pending_reg, pending_valid <= 0.
  - load_ack pulses in the next cycle.
  - If load coincides with the wrapping tick, value_in bypasses to display_reg directly, pending_valid is cleared, and load_ack still pulses.
- Outputs:
  - All outputs are registered; they reflect prescaler/index/display_reg with 1-cycle latency.
  - digit_nibble = display_reg nibble[index].
  - digit_sel:
    - All 1s while prescaler < DEAD_CYCLES.
    - Otherwise the index bit is low, unless the digit is blanked.
- Blanking:
  - Digit i is blanked when blank_lz = 1, i > 0, and every nibble from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - A blanked digit gets all-1s digit_sel; digit_nibble is still driven.
- Reset mid-frame: the scan restarts at index 0; any pending value is discarded.
- Width rules:
  - prescaler width = clog2(REFRESH_DIV).
  - index width = clog2(NUM_DIGITS).
  - Nibble selection is an indexed part-select; no arithmetic overflow is possible.

Decomposition:
- Shared package holds:
  - nibble width constant (4).
  - function computing the leading-zero blank mask from a packed value.
  - default REFRESH_DIV / DEAD_CYCLES constants reused by the board top.
- One sub-module, scan_prescaler (parameterised divider producing tick and the dead-time flag), is natural and is reused by the bounce-timing logic.
- The decoder is instantiated by the top, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
- Reset then idle:
  - digit_sel = 4'b1111 throughout reset.
  - After release, the slot cycle sequence is 1111, 1110, 1110, 1110; the next slot shows 1101.
  - digit_nibble = 0.
- load 16'h1A2F, blank_lz=0:
  - No display change until the next frame wrap; load_ack pulses once.
  - The following frame shows nibbles F, 2, A, 1 with selects 1110, 1101, 1011, 0111.
- Two loads in one frame (16'h1111, then 16'h2222):
  - Only 2222 is displayed after the wrap.
  - Exactly one load_ack.
- load 16'h0050, blank_lz=1:
  - Digits 3 and 2 select 1111 for their whole slots.
  - Digit 1 shows 5, digit 0 shows 0.
  - load 0: only digit 0 is enabled, nibble 0.
- load coincident with the wrapping tick, value 16'hBEEF:
  - BEEF is displayed from index 0 of the new frame.
  - load_ack 1 cycle later; pending_valid = 0.
- Assert rst mid-slot at index 2 with a load pending:
  - Outputs return to reset values immediately (async).
  - After release, the scan restarts at index 0 with display_reg = 0 and no load_ack.
